// File: rtl/sha3_msg_loader.sv
// sha3_msg_loader: AHB-lite master that streams producer message words into
// the SHA3 engine's message window as single-beat 32-bit writes to an
// incrementing, wrapping word address.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   msg_valid_i/msg_ready_o    producer word handshake
//   msg_data_i, msg_last_i     message word and end-of-message flag
//   busy_o                     FIFO non-empty or transfer in flight
//   done_o                     one-cycle pulse when the last word completes
//   err_o, err_clr_i           sticky AHB error flag and its clear/flush
//   haddr_o, hwdata_o, hsel_o, hwrite_o, htrans_o, hsize_o, hready_o
//                              AHB-lite master request signals
//   hresp_i, hreadyout_i       AHB-lite slave response
//
// Optional feature: define SHA3_MSG_LOADER_BYTESWAP_EN to byte-swap hwdata_o.

module sha3_msg_loader #(
    parameter int unsigned                AHB_ADDR_WIDTH = 32,
    parameter int unsigned                AHB_DATA_WIDTH = 32,
    parameter int unsigned                FIFO_DEPTH     = 4,
    parameter logic [AHB_ADDR_WIDTH-1:0]  MSG_ADDR       = AHB_ADDR_WIDTH'(32'h0000_0C00),
    parameter int unsigned                WIN_WORDS      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      msg_valid_i,
    output logic                      msg_ready_o,
    input  logic [31:0]               msg_data_i,
    input  logic                      msg_last_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    input  logic                      err_clr_i,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    output logic                      hsel_o,
    output logic                      hwrite_o,
    output logic                      hready_o,
    output logic [1:0]                htrans_o,
    output logic [2:0]                hsize_o,
    input  logic                      hresp_i,
    input  logic                      hreadyout_i
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WPTR_W = $clog2(WIN_WORDS);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    state_t            state, state_n;
    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [31:0]       head_data;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_n;
    logic [WPTR_W-1:0] wptr, wptr_n;
    logic              full, push, pop, flush, ahb_err;

    // Stream handshake and FIFO control
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign msg_ready_o = !full && (state != S_ERR) && !rst;
    assign push        = msg_valid_i && msg_ready_o;
    assign pop         = (state == S_DATA) && hreadyout_i && !hresp_i;
    assign ahb_err     = (state == S_DATA) && hreadyout_i && hresp_i;
    assign flush       = (state == S_ERR) && err_clr_i;
    assign head        = mem[rd_ptr];

    // Constant / feedthrough AHB signals
    assign hsize_o  = 3'b010;
    assign hready_o = hreadyout_i;
    assign busy_o   = (count != '0) || (state != S_IDLE);

`ifdef SHA3_MSG_LOADER_BYTESWAP_EN
    assign head_data = {head.data[7:0], head.data[15:8], head.data[23:16], head.data[31:24]};
`else
    assign head_data = head.data;
`endif

    // Next-state, next count and next window pointer
    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        count_n = count + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            count_n = '0;
        end
        case (state)
            // A push this cycle starts the address phase next cycle.
            S_IDLE: if ((count != '0) || push) state_n = S_ADDR;
            S_ADDR: if (hreadyout_i) state_n = S_DATA;
            S_DATA: begin
                if (hreadyout_i) begin
                    if (hresp_i) begin
                        state_n = S_ERR;
                    end else begin
                        wptr_n  = head.last ? '0 : wptr + WPTR_W'(1);
                        state_n = (count_n != '0) ? S_ADDR : S_IDLE;
                    end
                end
            end
            S_ERR: begin
                if (err_clr_i) begin
                    state_n = S_IDLE;
                    wptr_n  = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FIFO storage (data path, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{last: msg_last_i, data: msg_data_i};
        end
    end

    // State, pointers and registered AHB outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wptr     <= '0;
            hsel_o   <= 1'b0;
            hwrite_o <= 1'b0;
            htrans_o <= HTRANS_IDLE;
            haddr_o  <= MSG_ADDR;
            hwdata_o <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            wptr  <= wptr_n;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            hsel_o   <= (state_n == S_ADDR);
            hwrite_o <= (state_n == S_ADDR);
            htrans_o <= (state_n == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            // Address uses the post-completion pointer so back-to-back words advance.
            if (state_n == S_ADDR) begin
                haddr_o <= MSG_ADDR + AHB_ADDR_WIDTH'({wptr_n, 2'b00});
            end
            if ((state == S_ADDR) && (state_n == S_DATA)) begin
                hwdata_o <= AHB_DATA_WIDTH'(head_data);
            end
            done_o <= pop && head.last;
            if (ahb_err) begin
                err_o <= 1'b1;
            end else if (flush) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha3_msg_loader.sv
// Directed testbench for sha3_msg_loader: reset values, single-word latency,
// back-pressure, window wrap, AHB error/clear, reset mid-transfer and FIFO
// ordering while full.

module tb_sha3_msg_loader;

    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] IDLE   = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [31:0] msg_data_i;
    logic        msg_last_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        err_clr_i;
    logic [31:0] haddr_o;
    logic [31:0] hwdata_o;
    logic        hsel_o;
    logic        hwrite_o;
    logic        hready_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o;
    logic        hresp_i;
    logic        hreadyout_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha3_msg_loader dut (
        .clk         (clk),
        .rst         (rst),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .msg_data_i  (msg_data_i),
        .msg_last_i  (msg_last_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr_i),
        .haddr_o     (haddr_o),
        .hwdata_o    (hwdata_o),
        .hsel_o      (hsel_o),
        .hwrite_o    (hwrite_o),
        .hready_o    (hready_o),
        .htrans_o    (htrans_o),
        .hsize_o     (hsize_o),
        .hresp_i     (hresp_i),
        .hreadyout_i (hreadyout_i)
    );

    function automatic logic [31:0] exp_wdata(input logic [31:0] d);
`ifdef SHA3_MSG_LOADER_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_nonseq(input string tag);
        for (int k = 0; k < 8 && htrans_o != NONSEQ; k++) tick();
        chk(tag, 32'(htrans_o), 32'(NONSEQ));
    endtask

    // Producer pushes n words (base+i, last on the final one); slave holds
    // hreadyout low for the first 'hold' cycles. Checks address/data order.
    task automatic stream(input string tag, input int n, input int hold, input logic [31:0] base);
        int sent;
        int xfers;
        int dones;
        bit data_next;
        bit acc;
        sent = 0; xfers = 0; dones = 0; data_next = 0;
        for (int cyc = 0; cyc < 4*n + hold + 20; cyc++) begin
            hreadyout_i = (cyc >= hold);
            msg_valid_i = (sent < n);
            msg_data_i  = base + 32'(sent);
            msg_last_i  = (sent == n - 1);
            #1;
            if (hold > 0 && cyc == hold - 1) chk({tag, " ready when full"}, 32'(msg_ready_o), 0);
            if (data_next) chk({tag, " hwdata"}, hwdata_o, exp_wdata(base + 32'(xfers - 1)));
            data_next = 0;
            if (htrans_o == NONSEQ && hreadyout_i) begin
                chk({tag, " haddr"}, haddr_o, 32'h0C00 + 32'(4 * (xfers % 64)));
                xfers++;
                data_next = 1;
            end
            if (done_o) dones++;
            acc = msg_valid_i && msg_ready_o;
            tick();
            if (acc) sent++;
        end
        msg_valid_i = 0;
        msg_last_i  = 0;
        chk({tag, " words accepted"}, 32'(sent), 32'(n));
        chk({tag, " transfers"}, 32'(xfers), 32'(n));
        chk({tag, " done pulses"}, 32'(dones), 1);
    endtask

    initial begin
        rst = 1; msg_valid_i = 0; msg_data_i = 0; msg_last_i = 0;
        err_clr_i = 0; hresp_i = 0; hreadyout_i = 1;

        // Reset state
        tick(); tick();
        chk("rst ready", 32'(msg_ready_o), 0);
        chk("rst hsel", 32'(hsel_o), 0);
        chk("rst hwrite", 32'(hwrite_o), 0);
        chk("rst htrans", 32'(htrans_o), 32'(IDLE));
        chk("rst haddr", haddr_o, 32'h0C00);
        chk("rst hwdata", hwdata_o, 0);
        chk("rst hsize", 32'(hsize_o), 32'h2);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst done", 32'(done_o), 0);
        chk("rst err", 32'(err_o), 0);
        rst = 0;
        #1;
        chk("ready after rst", 32'(msg_ready_o), 1);

        // Single word, no wait states
        msg_valid_i = 1; msg_data_i = 32'hA1B2C3D4; msg_last_i = 1;
        tick();
        msg_valid_i = 0; msg_last_i = 0;
        chk("single c1 htrans", 32'(htrans_o), 32'(NONSEQ));
        chk("single c1 haddr", haddr_o, 32'h0C00);
        chk("single c1 hsel", 32'(hsel_o), 1);
        chk("single c1 hwrite", 32'(hwrite_o), 1);
        chk("single c1 busy", 32'(busy_o), 1);
        tick();
        chk("single c2 htrans", 32'(htrans_o), 32'(IDLE));
        chk("single c2 hsel", 32'(hsel_o), 0);
        chk("single c2 hwdata", hwdata_o, exp_wdata(32'hA1B2C3D4));
        tick();
        chk("single c3 done", 32'(done_o), 1);
        tick();
        chk("single c4 done", 32'(done_o), 0);
        chk("single c4 busy", 32'(busy_o), 0);

        // Back-pressure: slave stalls, five words offered
        hreadyout_i = 0;
        for (int i = 0; i < 4; i++) begin
            msg_valid_i = 1; msg_data_i = 32'hB000_0000 + 32'(i); msg_last_i = 0;
            chk("bp ready before push", 32'(msg_ready_o), 1);
            tick();
        end
        msg_data_i = 32'hB000_0004; msg_last_i = 1;
        chk("bp ready after 4 pushes", 32'(msg_ready_o), 0);
        chk("bp first htrans", 32'(htrans_o), 32'(NONSEQ));
        chk("bp first haddr", haddr_o, 32'h0C00);
        tick(); tick();
        chk("bp ready still full", 32'(msg_ready_o), 0);
        hreadyout_i = 1;
        tick();
        chk("bp w0 hwdata", hwdata_o, exp_wdata(32'hB000_0000));
        chk("bp ready in first data", 32'(msg_ready_o), 0);
        tick();
        chk("bp ready after completion", 32'(msg_ready_o), 1);
        chk("bp w1 haddr", haddr_o, 32'h0C04);
        tick();
        msg_valid_i = 0; msg_last_i = 0;
        chk("bp w1 hwdata", hwdata_o, exp_wdata(32'hB000_0001));
        for (int i = 2; i < 5; i++) begin
            wait_nonseq("bp nonseq wait");
            chk("bp haddr", haddr_o, 32'h0C00 + 32'(4 * i));
            tick();
            chk("bp hwdata", hwdata_o, exp_wdata(32'hB000_0000 + 32'(i)));
        end
        tick();
        chk("bp done", 32'(done_o), 1);

        // AHB error on the second word
        msg_valid_i = 1; msg_data_i = 32'hE000_0000; msg_last_i = 0;
        tick();
        msg_data_i = 32'hE000_0001;
        tick();
        msg_data_i = 32'hE000_0002;
        tick();
        msg_valid_i = 0;
        chk("err w1 htrans", 32'(htrans_o), 32'(NONSEQ));
        chk("err w1 haddr", haddr_o, 32'h0C04);
        tick();
        hreadyout_i = 0; hresp_i = 1;
        #1;
        chk("err hready feedthrough", 32'(hready_o), 0);
        chk("err w1 hwdata", hwdata_o, exp_wdata(32'hE000_0001));
        tick();
        hreadyout_i = 1; hresp_i = 1;
        tick();
        hresp_i = 0;
        chk("err flag", 32'(err_o), 1);
        chk("err ready", 32'(msg_ready_o), 0);
        chk("err busy", 32'(busy_o), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err no transfer", 32'(htrans_o), 32'(IDLE));
        end
        err_clr_i = 1;
        tick();
        err_clr_i = 0;
        chk("clr err", 32'(err_o), 0);
        chk("clr busy (fifo empty)", 32'(busy_o), 0);
        chk("clr ready", 32'(msg_ready_o), 1);
        msg_valid_i = 1; msg_data_i = 32'hE000_00FF; msg_last_i = 1;
        tick();
        msg_valid_i = 0; msg_last_i = 0;
        chk("clr next haddr", haddr_o, 32'h0C00);
        tick();
        chk("clr next hwdata", hwdata_o, exp_wdata(32'hE000_00FF));
        tick();
        chk("clr next done", 32'(done_o), 1);

        // Reset while in DATA with three words buffered
        msg_valid_i = 1; msg_last_i = 0;
        for (int i = 0; i < 4; i++) begin
            msg_data_i = 32'hD000_0000 + 32'(i);
            tick();
        end
        msg_valid_i = 0; hreadyout_i = 0;
        chk("rmid in data", 32'(htrans_o), 32'(IDLE));
        chk("rmid haddr before", haddr_o, 32'h0C04);
        rst = 1;
        #1;
        chk("rmid ready in rst", 32'(msg_ready_o), 0);
        tick();
        rst = 0; hreadyout_i = 1;
        chk("rmid htrans", 32'(htrans_o), 32'(IDLE));
        chk("rmid busy", 32'(busy_o), 0);
        chk("rmid haddr", haddr_o, 32'h0C00);
        chk("rmid hsel", 32'(hsel_o), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmid fifo empty", 32'(htrans_o), 32'(IDLE));
        end

        // FIFO order preserved when running full
        stream("full", 8, 6, 32'hC000_0000);

        // Window wrap over 66 words
        stream("wrap", 66, 0, 32'h0000_1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
